// File: rtl/alub_arb.sv
// rtl/alub_arb.sv - ALU B-input select arbiter and pipeline register
//
// Purpose: arbitrates the CPU micro-sequencer and the DMA engine for the
// ALU B operand path. It registers the winning one-hot select onto alub_reg.
// It supports locked multi-cycle ownership and bounded DMA starvation.
//
// Ports (W = SRCW+MODW):
//   clkc, reset             clock, synchronous active-high reset
//   cpu_req/sel/lock        CPU request, select vector, hold-ownership flag
//   cpu_gnt                 alub_reg carries the CPU select this cycle
//   dma_req/sel/lock        DMA request, select vector, hold-ownership flag
//   dma_gnt                 alub_reg carries the DMA select this cycle
//   alub_reg                registered select to the B-input mux (0 = no source)
//   alub_own                owner of current/last lock (0 CPU, 1 DMA)
//   sel_err                 bit0 CPU, bit1 DMA: last select had >1 source bit
module alub_arb #(
  parameter int SRCW       = 12,
  parameter int MODW       = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clkc,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic [SRCW+MODW-1:0] cpu_sel,
  input  logic                 cpu_lock,
  output logic                 cpu_gnt,
  input  logic                 dma_req,
  input  logic [SRCW+MODW-1:0] dma_sel,
  input  logic                 dma_lock,
  output logic                 dma_gnt,
  output logic [SRCW+MODW-1:0] alub_reg,
  output logic                 alub_own,
  output logic [1:0]           sel_err
);

  localparam int W = SRCW + MODW;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_LK = 2'd1,
    DMA_LK = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   alub_q, alub_d;
  logic           cpu_gnt_q, cpu_gnt_d;
  logic           dma_gnt_q, dma_gnt_d;
  logic           own_q, own_d;
  logic [1:0]     err_q, err_d;
  logic [3:0]     starve_q, starve_d;

  logic           cpu_bad, dma_bad;
  logic           cpu_ok, dma_ok;

  // Only the source bits are checked; modifier bits ride along untouched.
  assign cpu_bad = cpu_req && !$onehot0(cpu_sel[SRCW-1:0]);
  assign dma_bad = dma_req && !$onehot0(dma_sel[SRCW-1:0]);
  assign cpu_ok  = cpu_req && !cpu_bad;
  assign dma_ok  = dma_req && !dma_bad;

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    cpu_gnt_d = 1'b0;
    dma_gnt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_ok && dma_ok) begin
          // CPU has priority unless DMA has been starved long enough.
          if (starve_q == STARVE_LIM) dma_gnt_d = 1'b1;
          else                        cpu_gnt_d = 1'b1;
        end else if (cpu_ok) begin
          cpu_gnt_d = 1'b1;
        end else if (dma_ok) begin
          dma_gnt_d = 1'b1;
        end
        if (cpu_gnt_d && cpu_lock) begin
          state_d = CPU_LK;
          own_d   = 1'b0;
        end
        if (dma_gnt_d && dma_lock) begin
          state_d = DMA_LK;
          own_d   = 1'b1;
        end
      end
      CPU_LK: begin
        // The lock holder is the only candidate. Losing the request drops the lock.
        if (cpu_ok) begin
          cpu_gnt_d = 1'b1;
          state_d   = cpu_lock ? CPU_LK : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      DMA_LK: begin
        if (dma_ok) begin
          dma_gnt_d = 1'b1;
          state_d   = dma_lock ? DMA_LK : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cpu_gnt_d)      alub_d = cpu_sel;
    else if (dma_gnt_d) alub_d = dma_sel;
    else                alub_d = '0;

    err_d = {dma_bad, cpu_bad};

    // Starvation counts only legal DMA requests that lose. An illegal
    // request freezes the count so a glitchy select cannot erase DMA's credit.
    starve_d = starve_q;
    if (!dma_req)                    starve_d = 4'd0;
    else if (dma_bad)                starve_d = starve_q;
    else if (dma_gnt_d)              starve_d = 4'd0;
    else if (starve_q < STARVE_LIM)  starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clkc) begin
    if (reset) begin
      state_q   <= IDLE;
      alub_q    <= '0;
      cpu_gnt_q <= 1'b0;
      dma_gnt_q <= 1'b0;
      own_q     <= 1'b0;
      err_q     <= 2'b00;
      starve_q  <= 4'd0;
    end else begin
      state_q   <= state_d;
      alub_q    <= alub_d;
      cpu_gnt_q <= cpu_gnt_d;
      dma_gnt_q <= dma_gnt_d;
      own_q     <= own_d;
      err_q     <= err_d;
      starve_q  <= starve_d;
    end
  end

  assign alub_reg = alub_q;
  assign cpu_gnt  = cpu_gnt_q;
  assign dma_gnt  = dma_gnt_q;
  assign alub_own = own_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_alub_arb.sv
// tb/tb_alub_arb.sv - scoreboard testbench for alub_arb
//
// Drives directed vectors on the falling edge and pushes the hand-computed
// registered response for each vector. A monitor pops and compares after
// every rising edge.
module tb_alub_arb;

  localparam int W = 13;

  logic          clkc = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_lock, dma_req, dma_lock;
  logic [W-1:0]  cpu_sel, dma_sel;
  logic          cpu_gnt, dma_gnt, alub_own;
  logic [W-1:0]  alub_reg;
  logic [1:0]    sel_err;

  int checks = 0;
  int errors = 0;

  logic [W+4:0]  exp_q[$];
  string         name_q[$];

  localparam logic [W-1:0] SA = 13'h002;
  localparam logic [W-1:0] SB = 13'h010;
  localparam logic [W-1:0] Z  = 13'h000;

  always #5 clkc = ~clkc;

  alub_arb #(.SRCW(12), .MODW(1), .STARVE_MAX(4)) dut (
    .clkc(clkc), .reset(reset),
    .cpu_req(cpu_req), .cpu_sel(cpu_sel), .cpu_lock(cpu_lock), .cpu_gnt(cpu_gnt),
    .dma_req(dma_req), .dma_sel(dma_sel), .dma_lock(dma_lock), .dma_gnt(dma_gnt),
    .alub_reg(alub_reg), .alub_own(alub_own), .sel_err(sel_err)
  );

  task automatic step(input logic rst,
                      input logic creq, input logic [W-1:0] csel, input logic clk_lock,
                      input logic dreq, input logic [W-1:0] dsel, input logic dlk,
                      input logic ecg, input logic edg, input logic [W-1:0] ereg,
                      input logic [1:0] eerr, input logic eown, input string nm);
    @(negedge clkc);
    reset    = rst;
    cpu_req  = creq;  cpu_sel = csel;  cpu_lock = clk_lock;
    dma_req  = dreq;  dma_sel = dsel;  dma_lock = dlk;
    exp_q.push_back({ecg, edg, ereg, eerr, eown});
    name_q.push_back(nm);
    @(posedge clkc);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    logic [W+4:0] e;
    string        nm;
    forever begin
      @(posedge clkc);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({cpu_gnt, dma_gnt, alub_reg, sel_err, alub_own} !== e) begin
          errors++;
          $display("FAIL %s: got cg=%b dg=%b reg=%h err=%b own=%b, expected cg=%b dg=%b reg=%h err=%b own=%b",
                   nm, cpu_gnt, dma_gnt, alub_reg, sel_err, alub_own,
                   e[W+4], e[W+3], e[W+2:3], e[2:1], e[0]);
        end
        checks++;
        if ((cpu_gnt & dma_gnt) !== 1'b0) begin
          errors++;
          $display("FAIL %s_excl: got cg=%b dg=%b, expected not both", nm, cpu_gnt, dma_gnt);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_sel = Z; cpu_lock = 0;
    dma_req = 0; dma_sel = Z; dma_lock = 0;

    // Reset held with both requesting.
    step(1, 1,SA,1, 1,SB,1,  0,0,Z,2'b00,0, "reset0");
    step(1, 1,SA,1, 1,SB,1,  0,0,Z,2'b00,0, "reset1");
    // Single CPU request.
    step(0, 1,SA,0, 0,Z,0,   1,0,SA,2'b00,0, "cpu_single");
    step(0, 0,Z,0,  0,Z,0,   0,0,Z,2'b00,0,  "idle0");

    // Contention: CPU x4, DMA x1, twice.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        step(0, 1,SA,0, 1,SB,0, 1,0,SA,2'b00,0, "contend_cpu");
      step(0, 1,SA,0, 1,SB,0, 0,1,SB,2'b00,0, "contend_dma");
    end
    step(0, 0,Z,0, 0,Z,0, 0,0,Z,2'b00,0, "idle1");

    // CPU lock for 3 cycles, release on 4th; DMA waits throughout.
    for (int i = 0; i < 3; i++)
      step(0, 1,SA,1, 1,SB,0, 1,0,SA,2'b00,0, "lock_hold");
    step(0, 1,SA,0, 1,SB,0, 1,0,SA,2'b00,0, "lock_release");
    step(0, 0,Z,0,  1,SB,0, 0,1,SB,2'b00,0, "after_release_dma");
    step(0, 0,Z,0,  0,Z,0,  0,0,Z,2'b00,0,  "idle2");

    // Illegal DMA select must hold the starvation count at 3.
    for (int i = 0; i < 3; i++)
      step(0, 1,SA,0, 1,SB,0, 1,0,SA,2'b00,0, "pre_illegal_cpu");
    step(0, 0,Z,0,  1,13'h006,0, 0,0,Z,2'b10,0, "dma_illegal");
    step(0, 1,SA,0, 1,SB,0, 1,0,SA,2'b00,0, "post_illegal_cpu");
    step(0, 1,SA,0, 1,SB,0, 0,1,SB,2'b00,0, "post_illegal_dma");
    step(0, 1,13'h003,0, 1,13'h006,0, 0,0,Z,2'b11,0, "both_illegal");

    // Modifier passthrough and all-zero legal select.
    step(0, 1,13'h1001,0, 0,Z,0, 1,0,13'h1001,2'b00,0, "modifier");
    step(0, 1,Z,0, 0,Z,0,        1,0,Z,2'b00,0,        "zero_sel");

    // DMA lock, then reset mid-lock; CPU wins first afterwards.
    step(0, 0,Z,0,  1,SB,1, 0,1,SB,2'b00,1, "dma_lock_enter");
    step(0, 1,SA,0, 1,SB,1, 0,1,SB,2'b00,1, "dma_lock_hold");
    step(1, 1,SA,0, 1,SB,1, 0,0,Z,2'b00,0,  "reset_mid_lock");
    step(0, 1,SA,0, 1,SB,1, 1,0,SA,2'b00,0, "post_reset_cpu");
    step(0, 0,Z,0,  1,SB,1, 0,1,SB,2'b00,1, "dma_relock");
    step(0, 0,Z,0,  0,Z,0,  0,0,Z,2'b00,1,  "lock_drop_idle");

    @(posedge clkc);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alub_arb.md
# alub_arb

Arbiter and pipeline register for the ALU B-input select vector. Two requesters share the ALU/address-ALU B operand path: the CPU micro-sequencer and the on-chip DMA/block-move engine. Each requester presents a one-hot source select, and the block grants one per cycle. It registers the winner's select onto `alub_reg`, which drives the B-input multiplexer. It also supports multi-cycle locked ownership and starvation-bounded fairness for DMA.

## Interface

Parameters
- `SRCW`, 12: number of one-hot source bits, `sel[SRCW-1:0]` (AF, BC, DE, HL, IX, IY, SP, DIN, IO, TMP, PC, ADR).
- `MODW`, 1: modifier bits above the sources, `sel[SRCW+MODW-1:SRCW]` (SHR). Not checked; passed through with the winning source.
- `STARVE_MAX`, 4: consecutive lost arbitration cycles after which DMA gains priority. Range 1..15.

Ports (W = SRCW+MODW)
- `clkc`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU requests the B path this cycle.
- `cpu_sel`  in  W  CPU select vector.
- `cpu_lock`  in  1  keep ownership after this grant.
- `cpu_gnt`  out  1  `alub_reg` carries the CPU select this cycle.
- `dma_req`  in  1  DMA requests the B path this cycle.
- `dma_sel`  in  W  DMA select vector.
- `dma_lock`  in  1  keep ownership after this grant.
- `dma_gnt`  out  1  `alub_reg` carries the DMA select this cycle.
- `alub_reg`  out  W  pipelined select to the B-input mux. All-zero means no source, so the bus reads 0.
- `alub_own`  out  1  owner of the current/last lock: 0 CPU, 1 DMA.
- `sel_err`  out  2  bit0 CPU, bit1 DMA: the select presented last cycle had more than one source bit set.

## Operation

- States: `IDLE`, `CPU_LK` (CPU holds lock), `DMA_LK` (DMA holds lock).
- Legal request: `req`=1 and `sel[SRCW-1:0]` has zero or one bit set. Illegal requests are never granted. The matching `sel_err` bit is set for the next cycle, and the request is treated as absent for arbitration.
- Decision in `IDLE`, from legal requests only:
  - Only one requester: it wins.
  - Both: CPU wins, unless `starve_cnt == STARVE_MAX`, in which case DMA wins.
- `CPU_LK`: only the CPU is arbitrated and DMA requests lose.
  - CPU legal request with `cpu_lock`=1: win, stay in `CPU_LK`.
  - CPU legal request with `cpu_lock`=0: win, go to `IDLE`.
  - No CPU request, or illegal CPU request: `IDLE`; DMA is not granted in this cycle.
  - `DMA_LK` behaves symmetrically for DMA.
- Entering a lock: a win in `IDLE` with the winner's lock=1 moves to `CPU_LK`/`DMA_LK` and sets `alub_own`.
- Registered outputs at the edge closing decision cycle n:
  - `alub_reg` = winner's sel, or 0 if no winner.
  - Winner's `gnt`=1, the other 0.
  - `sel_err` updated.
- Requesters hold `req`/`sel`/`lock` stable until they see `gnt`. Dropping `req` before grant is legal and has no side effect.
- `starve_cnt` (4 bits):
  - Increments, saturating at `STARVE_MAX`, each cycle `dma_req` is legal and DMA loses.
  - Clears on DMA grant or when `dma_req`=0.
  - Holds when the DMA request is illegal.
- Starvation priority never preempts `CPU_LK`. It takes effect at the first `IDLE` decision.

## Timing

- Reset values: state `IDLE`, `alub_reg`=0, `cpu_gnt`=0, `dma_gnt`=0, `alub_own`=0, `sel_err`=0, `starve_cnt`=0.
- Reset asserted mid-lock aborts the lock. All outputs take reset values at that edge; requests in the reset cycle are ignored.
- Latency: request in cycle n produces grant and select in cycle n+1. Throughput is one grant per cycle, and back-to-back grants to the same requester are allowed.
- `alub_reg` and `gnt` are always coherent: `alub_reg` is nonzero only when exactly one `gnt` is high, but it is zero with `gnt` high for an all-zero legal sel.
- `cpu_gnt & dma_gnt` is never 1.
- Both requesters illegal in the same cycle: `sel_err`=2'b11, no grant.
- `STARVE_MAX`=1: DMA wins every other contested cycle.

## Test plan

- Reset and single request:
  - Hold `reset`=1 for 2 cycles with both requests high: all outputs 0.
  - Release, then `cpu_req`=1, `cpu_sel`=13'h002 (BC): next cycle `cpu_gnt`=1, `alub_reg`=13'h002.
- Contention and starvation: `STARVE_MAX`=4, both requesting continuously, no locks:
  - Grants are CPU×4, then DMA×1, repeating.
  - `alub_reg` alternates between the corresponding sel values.
- Lock hold and release:
  - CPU requests with `lock`=1 for 3 cycles, then `lock`=0, while DMA requests throughout.
  - CPU gets 4 consecutive grants with `alub_own`=0; DMA is granted on the cycle after the release decision.
- Illegal select:
  - `dma_sel`=13'h006 with `dma_req`=1: next cycle `sel_err`=2'b10, `dma_gnt`=0, `alub_reg`=0.
  - `starve_cnt` is unchanged.
- Reset mid-lock:
  - DMA in `DMA_LK`, assert `reset` for one cycle: outputs reset.
  - After release, a pending CPU request is granted first.
- Modifier passthrough:
  - `cpu_sel`=13'h1001 (AF+SHR): granted, `alub_reg`=13'h1001, `sel_err`=0.
